// File: rtl/hawk_tbl_rd_engine_if.sv
// Lookup request/response channel plus single-beat AXI4 read channel of the HAWK table
// read engine. The engine uses the slave modport: it serves lookups and masters AXI reads.
// The master modport is the environment: the lookup client plus the memory behind AXI.
interface hawk_tbl_rd_engine_if #(
  parameter int unsigned AXI_ADDR_W = 64,
  parameter int unsigned AXI_DATA_W = 512,
  parameter int unsigned LST_ENT_W  = 128,
  parameter int unsigned ID_W       = 20
);
  // Lookup request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_tbl;
  logic [ID_W-1:0]       req_id;
  logic                  inv;
  // AXI read address / data
  logic                  m_arvalid;
  logic                  m_arready;
  logic [AXI_ADDR_W-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [AXI_DATA_W-1:0] m_rdata;
  logic [1:0]            m_rresp;
  // Lookup response
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [LST_ENT_W-1:0]  rsp_entry;
  logic                  rsp_hit;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_tbl, req_id, inv,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    input  rsp_ready,
    output req_ready, m_arvalid, m_araddr, m_arlen, m_rready,
    output rsp_valid, rsp_entry, rsp_hit, rsp_err
  );

  modport master (
    output req_valid, req_tbl, req_id, inv,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    output rsp_ready,
    input  req_ready, m_arvalid, m_araddr, m_arlen, m_rready,
    input  rsp_valid, rsp_entry, rsp_hit, rsp_err
  );
endinterface

// File: rtl/hawk_tbl_rd_engine.sv
// HAWK ATT / list-entry fetch engine. Turns a 1-based entry ID into a cache-line address,
// fetches the line with a single-beat AXI4 read and returns the addressed entry. Each table
// keeps its last fetched line so that lookups landing in the same line skip AXI entirely.
module hawk_tbl_rd_engine #(
  parameter int unsigned           AXI_ADDR_W  = 64,
  parameter int unsigned           AXI_DATA_W  = 512,
  parameter int unsigned           ATT_ENT_W   = 64,
  parameter int unsigned           LST_ENT_W   = 128,
  parameter int unsigned           ID_W        = 20,
  parameter logic [AXI_ADDR_W-1:0] ATT_BASE    = '0,
  parameter logic [AXI_ADDR_W-1:0] LST_BASE    = '0,
  parameter int unsigned           LINE_BUF_EN = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  hawk_tbl_rd_engine_if.slave bus
);

  // Line geometry; entry widths and the line width are powers of two, so divide/modulo
  // reduce to shift/mask.
  localparam int unsigned ATT_EPL  = AXI_DATA_W / ATT_ENT_W;
  localparam int unsigned LST_EPL  = AXI_DATA_W / LST_ENT_W;
  localparam int unsigned ATT_LSB  = $clog2(ATT_EPL);
  localparam int unsigned LST_LSB  = $clog2(LST_EPL);
  localparam int unsigned LINE_LSB = $clog2(AXI_DATA_W / 8);

  localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0] ATT_MASK = ID_W'(ATT_EPL - 1);
  localparam logic [ID_W-1:0] LST_MASK = ID_W'(LST_EPL - 1);
  localparam logic [1:0]      RESP_OK  = 2'b00;

  typedef enum logic [1:0] {StIdle, StAr, StR, StRsp} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  arvalid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic [LST_ENT_W-1:0]  rsp_entry_q;
  logic                  rsp_hit_q;
  logic                  rsp_err_q;

  // Registered request context
  logic                  tbl_q;
  logic [ID_W-1:0]       line_q;
  logic [ID_W-1:0]       slot_q;
  // An invalidate seen while the line was in flight: return the data but do not cache it.
  logic                  inv_seen_q;

  // Per-table last-line buffers, index 0 = ATT, 1 = LIST
  logic [1:0]            buf_vld_q;
  logic [ID_W-1:0]       buf_tag_q  [2];
  logic [AXI_DATA_W-1:0] buf_data_q [2];

  // Request decode for the accept cycle
  logic [ID_W-1:0]       idx_c;
  logic [ID_W-1:0]       line_c;
  logic [ID_W-1:0]       slot_c;
  logic [AXI_ADDR_W-1:0] base_c;
  logic [AXI_ADDR_W-1:0] addr_c;
  logic                  id_zero_c;
  logic                  hit_c;
  logic [LST_ENT_W-1:0]  hit_entry_c;
  logic [LST_ENT_W-1:0]  cap_entry_c;
  logic                  cache_fill_c;

  // Pick one entry out of a line; ATT entries come back zero-extended.
  function automatic logic [LST_ENT_W-1:0] extract(input logic [AXI_DATA_W-1:0] line,
                                                   input logic                  tbl,
                                                   input logic [ID_W-1:0]       slot);
    logic [AXI_DATA_W-1:0] sh;
    logic [LST_ENT_W-1:0]  ent;
    ent = '0;
    if (tbl) begin
      sh = line >> (32'(slot) * LST_ENT_W);
      ent = sh[LST_ENT_W-1:0];
    end else begin
      sh = line >> (32'(slot) * ATT_ENT_W);
      ent[ATT_ENT_W-1:0] = sh[ATT_ENT_W-1:0];
    end
    return ent;
  endfunction

  // Address, slot and buffer-hit decode of the incoming request
  always_comb begin
    idx_c     = bus.req_id - ID_ONE;
    id_zero_c = (bus.req_id == '0);
    if (bus.req_tbl) begin
      line_c = idx_c >> LST_LSB;
      slot_c = idx_c & LST_MASK;
      base_c = LST_BASE;
    end else begin
      line_c = idx_c >> ATT_LSB;
      slot_c = idx_c & ATT_MASK;
      base_c = ATT_BASE;
    end
    addr_c = base_c + (AXI_ADDR_W'(line_c) << LINE_LSB);
    // An invalidate arriving with the request wins over a buffer match.
    hit_c = (LINE_BUF_EN != 0) && buf_vld_q[bus.req_tbl] &&
            (buf_tag_q[bus.req_tbl] == line_c) && !bus.inv;
    hit_entry_c = extract(buf_data_q[bus.req_tbl], bus.req_tbl, slot_c);
  end

  // Entry extraction and cacheability of the returning R beat
  always_comb begin
    cap_entry_c  = extract(bus.m_rdata, tbl_q, slot_q);
    cache_fill_c = (LINE_BUF_EN != 0) && !inv_seen_q && !bus.inv &&
                   (bus.m_rresp == RESP_OK);
  end

  // Control FSM with registered outputs and line-buffer maintenance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_entry_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      tbl_q       <= 1'b0;
      line_q      <= '0;
      slot_q      <= '0;
      inv_seen_q  <= 1'b0;
      buf_vld_q   <= '0;
    end else begin
      if (bus.inv) begin
        buf_vld_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            tbl_q       <= bus.req_tbl;
            line_q      <= line_c;
            slot_q      <= slot_c;
            inv_seen_q  <= 1'b0;
            if (id_zero_c) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_entry_q <= '0;
              rsp_hit_q   <= 1'b0;
              rsp_err_q   <= 1'b1;
            end else if (hit_c) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_entry_q <= hit_entry_c;
              rsp_hit_q   <= 1'b1;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q   <= StAr;
              arvalid_q <= 1'b1;
              araddr_q  <= addr_c;
            end
          end
        end
        StAr: begin
          if (bus.inv) begin
            inv_seen_q <= 1'b1;
          end
          if (bus.m_arready) begin
            state_q   <= StR;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        StR: begin
          if (bus.m_rvalid) begin
            state_q     <= StRsp;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b0;
            if (bus.m_rresp == RESP_OK) begin
              rsp_entry_q <= cap_entry_c;
              rsp_err_q   <= 1'b0;
              if (cache_fill_c) begin
                buf_vld_q[tbl_q]  <= 1'b1;
                buf_tag_q[tbl_q]  <= line_q;
                buf_data_q[tbl_q] <= bus.m_rdata;
              end
            end else begin
              rsp_entry_q      <= '0;
              rsp_err_q        <= 1'b1;
              buf_vld_q[tbl_q] <= 1'b0;
            end
          end else if (bus.inv) begin
            inv_seen_q <= 1'b1;
          end
        end
        StRsp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = 8'd0;
  assign bus.m_rready  = rready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_entry = rsp_entry_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
